mux2_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 2-to-1 data mux between two packet sources and one sink. Arbitrates between two valid/ready requesters, drives the mux select, and holds the grant for a whole packet, from the first beat to the beat marked `last`. Releases a stalled grant after a programmable idle timeout and flags the abort. Sits directly in front of the 2-to-1 mux datapath, which it steers through `select`.

---
 rtl/mux2_rr_arbiter.sv | 92 +++++++++
 tb/tb_mux2_rr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin packet arbiter steering a 2:1 mux, with idle-timeout release
module mux2_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_last,
    output logic             in2_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             select,
    output logic             busy,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE, G1, G2} state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic       select_q, select_d;
    logic       timeout_err_q, timeout_err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       g_valid, g_last, xfer;

    // select_q always names the granted requester while a grant is held
    assign busy        = state_q != IDLE;
    assign select      = select_q;
    assign timeout_err = timeout_err_q;
    assign g_valid     = select_q ? in2_valid : in1_valid;
    assign g_last      = select_q ? in2_last : in1_last;
    assign out_valid   = busy & g_valid;
    assign out_data    = select_q ? in2_data : in1_data;
    assign out_last    = g_last;
    assign in1_ready   = busy & ~select_q & out_ready;
    assign in2_ready   = busy & select_q & out_ready;
    assign xfer        = out_valid & out_ready;

    // arbitrate in IDLE; while granted, hold until the last beat or until the idle count hits TIMEOUT
    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        select_d      = select_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (in1_valid | in2_valid) begin
                select_d = in2_valid & (~in1_valid | prio_q);
                state_d  = select_d ? G2 : G1;
                prio_d   = ~select_d;
                cnt_d    = '0;
            end
        end else if (xfer) begin
            cnt_d = '0;
            if (g_last)
                state_d = IDLE;
        end else if (!g_valid) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == TO) begin
                state_d       = IDLE;
                cnt_d         = '0;
                timeout_err_d = 1'b1;
            end
        end
    end

    // control registers; reset abandons any packet without flagging a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            select_q      <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            select_q      <= select_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_mux2_rr_arbiter;
    localparam int W  = 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v1, v2, l1, l2, ordy;
    logic [W-1:0] d1, d2, od;
    logic r1, r2, ov, ol, sel, busy, terr;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_valid(v1), .in1_data(d1), .in1_last(l1), .in1_ready(r1),
        .in2_valid(v2), .in2_data(d2), .in2_last(l2), .in2_ready(r2),
        .out_valid(ov), .out_data(od), .out_last(ol), .out_ready(ordy),
        .select(sel), .busy(busy), .timeout_err(terr)
    );

    typedef struct {
        logic v1, l1, v2, l2, rdy;
        logic [7:0] d1, d2;
        logic ov, ol, r1, r2, sel, busy;
        logic [7:0] od;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic l;
    } beat_t;

    beat_t q1[$], q2[$];
    int own, prio, msel, cnt, cyc;
    bit mterr, pbusy;
    int order[$];
    bit h_busy[256], h_sel[256], h_terr[256], h_x[256];
    logic [W-1:0] h_od[256];

    function automatic vec_t mk(logic [4:0] i, logic [7:0] a, logic [7:0] b, logic [5:0] e, logic [7:0] o);
        vec_t r;
        {r.v1, r.l1, r.v2, r.l2, r.rdy} = i;
        r.d1 = a;
        r.d2 = b;
        {r.ov, r.ol, r.r1, r.r2, r.sel, r.busy} = e;
        r.od = o;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(int who, logic [W-1:0] d, logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        if (who == 1) q1.push_back(b);
        else q2.push_back(b);
    endtask

    task automatic drive();
        v1 = q1.size() != 0;
        v2 = q2.size() != 0;
        d1 = '0; l1 = 1'b0; d2 = '0; l2 = 1'b0;
        if (v1) begin d1 = q1[0].d; l1 = q1[0].l; end
        if (v2) begin d2 = q2[0].d; l2 = q2[0].l; end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        ordy = 1'b1;
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        own = 0; prio = 1; msel = 0; cnt = 0; mterr = 1'b0;
        cyc = 0; pbusy = 1'b0;
        order.delete();
    endtask

    // one clock: compare DUT against the model, advance the model, let sources retire accepted beats
    task automatic tick();
        logic gv, gl;
        logic [W-1:0] gd;
        int who;
        bit nterr;
        @(negedge clk);
        who = own;
        gv = (own == 1 && v1) || (own == 2 && v2);
        gl = own == 1 ? l1 : l2;
        gd = own == 1 ? d1 : d2;
        chk("busy", busy, own != 0);
        chk("select", sel, msel);
        chk("out_valid", ov, gv);
        chk("in1_ready", r1, own == 1 && ordy);
        chk("in2_ready", r2, own == 2 && ordy);
        chk("timeout_err", terr, mterr);
        if (gv) begin
            chk("out_data", od, gd);
            chk("out_last", ol, gl);
        end
        if (cyc < 256) begin
            h_busy[cyc] = busy; h_sel[cyc] = sel; h_terr[cyc] = terr;
            h_x[cyc] = ov & ordy; h_od[cyc] = od;
        end
        if (busy && !pbusy) order.push_back(sel);
        pbusy = busy;
        cyc++;
        nterr = 1'b0;
        if (own == 0) begin
            if (v1 || v2) begin
                own = (v1 && v2) ? prio : (v1 ? 1 : 2);
                prio = 3 - own;
                msel = own - 1;
                cnt = 0;
            end
        end else if (gv && ordy) begin
            cnt = 0;
            if (gl) own = 0;
        end else if (!gv) begin
            cnt++;
            if (cnt == TO) begin
                own = 0;
                cnt = 0;
                nterr = 1'b1;
            end
        end
        mterr = nterr;
        @(posedge clk); #1;
        if (gv && ordy) begin
            if (who == 1) void'(q1.pop_front());
            else void'(q2.pop_front());
        end
        drive();
    endtask

    initial begin
        vec_t tbl[11];
        logic [W-1:0] got[$];
        int nt;
        ordy = 1'b1; v1 = 1'b1; v2 = 1'b1; l1 = 1'b0; l2 = 1'b0; d1 = '0; d2 = '0;

        // reset held with both requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", ov, 0);
        chk("rst_in1_ready", r1, 0);
        chk("rst_in2_ready", r2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", terr, 0);
        chk("rst_select", sel, 0);

        // inputs {v1,l1,v2,l2,rdy}, d1, d2, expected {ov,ol,r1,r2,sel,busy}, od
        tbl[0]  = mk(5'b10111, 8'h11, 8'h22, 6'b000000, 8'h00);
        tbl[1]  = mk(5'b10111, 8'h11, 8'h22, 6'b101001, 8'h11);
        tbl[2]  = mk(5'b11110, 8'h12, 8'h22, 6'b110001, 8'h12);
        tbl[3]  = mk(5'b11111, 8'h12, 8'h22, 6'b111001, 8'h12);
        tbl[4]  = mk(5'b00111, 8'h00, 8'h22, 6'b000000, 8'h00);
        tbl[5]  = mk(5'b00111, 8'h00, 8'h22, 6'b110111, 8'h22);
        tbl[6]  = mk(5'b11111, 8'h33, 8'h44, 6'b000010, 8'h00);
        tbl[7]  = mk(5'b11111, 8'h33, 8'h44, 6'b111001, 8'h33);
        tbl[8]  = mk(5'b11111, 8'h33, 8'h44, 6'b000000, 8'h00);
        tbl[9]  = mk(5'b11111, 8'h33, 8'h44, 6'b110111, 8'h44);
        tbl[10] = mk(5'b00001, 8'h00, 8'h00, 6'b000010, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            {v1, l1, v2, l2, ordy} = {tbl[i].v1, tbl[i].l1, tbl[i].v2, tbl[i].l2, tbl[i].rdy};
            d1 = tbl[i].d1;
            d2 = tbl[i].d2;
            @(negedge clk);
            chk("vec_out_valid", ov, tbl[i].ov);
            chk("vec_in1_ready", r1, tbl[i].r1);
            chk("vec_in2_ready", r2, tbl[i].r2);
            chk("vec_select", sel, tbl[i].sel);
            chk("vec_busy", busy, tbl[i].busy);
            chk("vec_timeout_err", terr, 0);
            if (tbl[i].ov) begin
                chk("vec_out_data", od, tbl[i].od);
                chk("vec_out_last", ol, tbl[i].ol);
            end
            @(posedge clk); #1;
        end

        // round-robin with continuous 3-beat packets from both sides
        reset_dut();
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 3; b++) begin
                push(1, W'(8'h11 + 3 * p + b), b == 2);
                push(2, W'(8'h22 + 3 * p + b), b == 2);
            end
        drive();
        repeat (30) tick();
        chk("rr_grants", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++) chk("rr_order", order[i], i % 2);
        for (int c = 0; c < 25; c++) chk("rr_bubble", h_busy[c], c % 4 != 0);

        // backpressure on a 4-beat in2 packet
        reset_dut();
        for (int b = 0; b < 4; b++) push(2, W'(8'hA0 + b), b == 3);
        drive();
        for (int i = 0; i < 12; i++) begin
            ordy = i % 2 == 0;
            tick();
        end
        got.delete();
        nt = 0;
        for (int c = 0; c < 12; c++) begin
            if (h_x[c]) got.push_back(h_od[c]);
            nt += int'(h_terr[c]);
        end
        chk("bp_beats", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("bp_data", got[i], 8'hA0 + i);
        chk("bp_no_timeout", nt, 0);

        // timeout: in1 sends one beat without last then goes quiet; in2 waits
        reset_dut();
        push(1, 8'h77, 1'b0);
        drive();
        tick();
        push(2, 8'h88, 1'b1);
        drive();
        repeat (9) tick();
        chk("to_first_xfer", h_x[1], 1);
        chk("to_early", h_terr[5], 0);
        chk("to_pulse", h_terr[6], 1);
        chk("to_idle", h_busy[6], 0);
        chk("to_pulse_width", h_terr[7], 0);
        chk("to_g2_busy", h_busy[7], 1);
        chk("to_g2_sel", h_sel[7], 1);

        // back-to-back single-beat packets
        reset_dut();
        repeat (4) push(1, 8'h5A, 1'b1);
        drive();
        repeat (8) tick();
        for (int c = 0; c < 8; c++) begin
            chk("sb_busy", h_busy[c], c % 2);
            chk("sb_xfer", h_x[c], c % 2);
        end

        // reset asserted while beat 2 of 4 is on the bus
        reset_dut();
        for (int b = 0; b < 4; b++) push(1, W'(8'hB0 + b), b == 3);
        drive();
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rm_out_valid", ov, 0);
        chk("rm_in1_ready", r1, 0);
        chk("rm_in2_ready", r2, 0);
        chk("rm_busy", busy, 0);
        chk("rm_select", sel, 0);
        chk("rm_timeout_err", terr, 0);
        @(posedge clk); #1;
        chk("rm_hold_timeout_err", terr, 0);

        // random traffic with gaps and backpressure
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (q1.size() < 4 && $urandom_range(0, 9) < 3) push(1, W'($urandom), $urandom_range(0, 2) == 0);
            if (q2.size() < 4 && $urandom_range(0, 9) < 3) push(2, W'($urandom), $urandom_range(0, 2) == 0);
            ordy = $urandom_range(0, 3) != 0;
            drive();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
